apb_master_nslv: RTL and testbench
==================================

# apb_master_nslv

Parametrised APB3 master bridging the core's internal single-request bus to NUM_SLAVES memory-mapped peripherals. It replaces the fixed five-slave master. Additions over that design:
- compile-time slave count and address map;
- PSLVERR and PSTRB support;
- decode-error reporting;
- a registered response handshake;
- an optional ACCESS-phase timeout.

## Interface
Parameters:
- NUM_SLAVES, 5, number of APB slaves (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- BASE_ADDR, 32'h1000_0000, address of slave 0 window
- SLOT_BITS, 12, log2 of each slave window size (4 KiB)
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort (≥2)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- PADDR  out  ADDR_W  latched request address
- PWRITE  out  1  latched direction
- PENABLE  out  1  ACCESS-phase flag
- PWDATA  out  DATA_W  latched write data
- PSTRB  out  DATA_W/8  latched write strobes; 0 on reads
- PSEL  out  NUM_SLAVES  one-hot slave select
- PRDATA  in  NUM_SLAVES*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error
- req_valid  in  1  request present
- req_ready  out  1  master can accept; high only in IDLE
- req_write, req_addr, req_wdata, req_strb  in  1/ADDR_W/DATA_W/DATA_W/8  request fields, sampled when req_valid & req_ready
- rsp_valid  out  1  single-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, 0 for writes and errors
- rsp_err  out  1  slave error, decode error or timeout

## Operation
States: IDLE, SETUP, ACCESS.

IDLE
- req_ready=1.
- On req_valid, all request fields are latched into PADDR/PWRITE/PWDATA/PSTRB.
- Decode: hit when BASE_ADDR ≤ addr < BASE_ADDR + (NUM_SLAVES << SLOT_BITS). Index = (addr − BASE_ADDR) >> SLOT_BITS.
- Hit: go to SETUP.
- Miss: no bus cycle; stay in IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.

SETUP
- PSEL[index]=1, PENABLE=0.
- Always goes to ACCESS.

ACCESS
- PSEL[index]=1, PENABLE=1.
- PREADY/PSLVERR/PRDATA are taken only from the selected slave.
- On PREADY[index]=1: go to IDLE and register the response.
  - rsp_err=PSLVERR[index].
  - rsp_rdata=PRDATA[index] on a read with no error, else 0.

Outside SETUP and ACCESS:
- PSEL=0 and PENABLE=0.
- PADDR/PWRITE/PWDATA/PSTRB hold their last values.

Requests are never queued. req_valid while req_ready=0 is ignored.

Reset values: every output is 0 except req_ready=1; state is IDLE.

## Timing
- Zero-wait transfer accepted at cycle T: SETUP at T+1, ACCESS at T+2, rsp_valid at T+3. req_ready=1 again at T+3, so back-to-back throughput is one transfer per 3 cycles.
- Each low-PREADY ACCESS cycle adds one cycle of latency.
- Decode-miss response arrives at T+1.
- rsp_valid is high for exactly one cycle and carries no backpressure.
- PRESET asserted mid-transfer: PSEL/PENABLE drop asynchronously, no rsp_valid is generated, and the transfer is lost.
- PREADY=1 together with PSLVERR=1: the transfer completes with rsp_err=1.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter of ACCESS cycles, width $clog2(TIMEOUT_CYCLES+1), clears on entry to SETUP.
  - If PREADY[index] is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the master goes to IDLE and responds next cycle with rsp_err=1, rsp_rdata=0.
  - PREADY=1 in that same cycle takes priority: normal completion.
- APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package apb_pkg:
  - apb_state_e enum (IDLE, SETUP, ACCESS);
  - default BASE_ADDR and SLOT_BITS localparams;
  - a function computing slot index and hit from address, base, slot bits and slave count.
- Sub-module apb_addr_decoder, combinational:
  - inputs: address, enable;
  - outputs: one-hot PSEL vector, index, hit.
  - Read data, ready and error are selected inline in the master using the registered index.

## Test plan
- NUM_SLAVES=5, write 32'hA5A5_0001 to 32'h1000_2004, strb 4'hF, PREADY tied 1 → PSEL=5'b00100 at T+1 and T+2, PENABLE only at T+2, rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read 32'h1000_4010, slave 4 returns 32'hDEAD_BEEF after 3 wait cycles → PSEL[4] held through 4 ACCESS cycles, rsp_valid at T+6 with rsp_rdata=32'hDEAD_BEEF.
- Read 32'h1000_5000 (out of range) → PSEL stays 0, rsp_valid at T+1 with rsp_err=1; req_ready never drops.
- Slave 1 asserts PSLVERR with PREADY on a read → rsp_err=1, rsp_rdata=0.
- APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, PREADY held 0 → abort after the 16th ACCESS cycle, rsp_err=1, PSEL=0 the following cycle. Rerun with PREADY=1 in the 16th cycle → normal completion.
- PRESET pulsed during ACCESS → PSEL/PENABLE=0 immediately, no rsp_valid, req_ready=1 after reset release.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types, defaults and the address-decode helper for the parametrised
// APB3 master (apb_master_nslv) and its address decoder (apb_addr_decoder).
//
// Contents:
//   apb_state_e        IDLE / SETUP / ACCESS bus phase
//   APB_BASE_ADDR_DEF  default address of the slave 0 window
//   APB_SLOT_BITS_DEF  default log2 of each slave window size
//   apb_decode_t       {hit, idx} result of an address decode
//   apb_decode()       slot index + hit from address, base, slot bits, count
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] APB_BASE_ADDR_DEF = 32'h1000_0000;
    localparam int          APB_SLOT_BITS_DEF = 12;

    // Up to 16 slaves, so a 4-bit index always suffices; the decode is done
    // at 64 bits so any supported address width fits.
    localparam int APB_IDX_MAX_W = 4;
    localparam int APB_DEC_W     = 64;

    typedef struct packed {
        logic                     hit;
        logic [APB_IDX_MAX_W-1:0] idx;
    } apb_decode_t;

    // An address below the base wraps to a huge offset, so the explicit
    // addr >= base term is what keeps those addresses from aliasing.
    function automatic apb_decode_t apb_decode(
        input logic [APB_DEC_W-1:0] addr,
        input logic [APB_DEC_W-1:0] base,
        input int                   slot_bits,
        input int                   num_slaves
    );
        apb_decode_t          res;
        logic [APB_DEC_W-1:0] slot;
        slot    = (addr - base) >> slot_bits;
        res.hit = (addr >= base) && (slot < APB_DEC_W'(num_slaves));
        res.idx = slot[APB_IDX_MAX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Combinational slave decoder for apb_master_nslv. Maps an address onto one
// of NUM_SLAVES equal windows of 2**SLOT_BITS bytes starting at BASE_ADDR.
//
// Ports:
//   addr_i  in   ADDR_W      address to decode
//   en_i    in   1           gates the one-hot select output
//   psel_o  out  NUM_SLAVES  one-hot select (all zero on miss or !en_i)
//   idx_o   out  IDX_W       slot index (meaningful only when hit_o)
//   hit_o   out  1           address falls inside the slave map
// ---------------------------------------------------------------------------
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 5,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(APB_BASE_ADDR_DEF),
    parameter int                SLOT_BITS  = APB_SLOT_BITS_DEF,
    parameter int                IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  en_i,
    output logic [NUM_SLAVES-1:0] psel_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  hit_o
);

    apb_decode_t dec;

    // Decode once and derive index, hit and the gated one-hot select from it.
    always_comb begin
        dec    = apb_decode(APB_DEC_W'(addr_i), APB_DEC_W'(BASE_ADDR), SLOT_BITS, NUM_SLAVES);
        hit_o  = dec.hit;
        idx_o  = dec.idx[IDX_W-1:0];
        psel_o = '0;
        if (en_i && dec.hit) begin
            psel_o[dec.idx[IDX_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_nslv.sv
// ---------------------------------------------------------------------------
// apb_master_nslv
// Parametrised APB3 master bridging the core's single-request bus to
// NUM_SLAVES memory-mapped peripherals. One transfer in flight at a time;
// a request that misses the slave map is answered with an error response
// without running a bus cycle.
//
// Build option:
//   APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that has not seen
//                          PREADY by its TIMEOUT_CYCLES-th cycle is aborted
//                          with rsp_err=1.
//
// Ports:
//   PCLK, PRESET        clock, asynchronous active-high reset
//   PADDR/PWRITE/PWDATA latched request address, direction, write data
//   PSTRB               latched write strobes (0 on reads)
//   PSEL, PENABLE       one-hot slave select, ACCESS-phase flag
//   PRDATA/PREADY/PSLVERR per-slave read data (slave i at i*DATA_W), ready, error
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_write/addr/wdata/strb request fields
//   rsp_valid           single-cycle completion pulse
//   rsp_rdata, rsp_err  read data (0 for writes/errors), error flag
// ---------------------------------------------------------------------------
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES     = 5,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(APB_BASE_ADDR_DEF),
    parameter int                SLOT_BITS      = APB_SLOT_BITS_DEF,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_strb,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    apb_state_e state_q, state_d;

    logic [ADDR_W-1:0]     paddr_q;
    logic                  pwrite_q;
    logic [DATA_W-1:0]     pwdata_q;
    logic [DATA_W/8-1:0]   pstrb_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    logic [ADDR_W-1:0]     dec_addr;
    logic                  dec_en;
    logic [NUM_SLAVES-1:0] dec_psel;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_hit;

    logic                  accept;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  timeout;

    // In IDLE the decoder looks at the incoming request to decide hit/miss;
    // during a transfer it re-decodes the latched address to drive PSEL, so
    // PSEL falls as soon as the state register is reset.
    assign dec_addr = (state_q == IDLE) ? req_addr : paddr_q;
    assign dec_en   = (state_q == SETUP) || (state_q == ACCESS);
    assign accept   = req_valid && (state_q == IDLE);

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .SLOT_BITS  (SLOT_BITS),
        .IDX_W      (IDX_W)
    ) u_dec (
        .addr_i (dec_addr),
        .en_i   (dec_en),
        .psel_o (dec_psel),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    // Only the selected slave's return signals are ever looked at.
    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[int'(idx_q)*DATA_W +: DATA_W];

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts ACCESS cycles of the current transfer; value k means this is
    // the (k+1)-th ACCESS cycle, so the abort fires when it reads
    // TIMEOUT_CYCLES-1 with PREADY still low.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else if (state_d == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ACCESS) && !sel_ready &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a decode miss never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && dec_hit) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready || timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus-phase outputs decoded straight from the state register.
    always_comb begin
        PSEL      = '0;
        PENABLE   = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            SETUP: begin
                PSEL = dec_psel;
            end
            ACCESS: begin
                PSEL    = dec_psel;
                PENABLE = 1'b1;
            end
            default: begin
                PSEL = '0;
            end
        endcase
    end

    // Request fields are captured on every accepted request, hit or miss,
    // and otherwise hold so the bus stays quiet between transfers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            idx_q    <= '0;
        end else if (accept) begin
            paddr_q  <= req_addr;
            pwrite_q <= req_write;
            pwdata_q <= req_wdata;
            pstrb_q  <= req_write ? req_strb : '0;
            idx_q    <= dec_idx;
        end
    end

    // Registered response: a one-cycle pulse for a decode miss, a normal
    // completion or a timeout. Data and error are cleared between pulses.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (accept && !dec_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
            end else if ((state_q == ACCESS) && sel_ready) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= sel_err;
                rsp_rdata_q <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
            end else if (timeout) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// ---------------------------------------------------------------------------
// tb_apb_master_nslv
// Directed bench for apb_master_nslv with its default parameters (five
// slaves at 32'h1000_0000, 4 KiB windows). Slave behaviour is driven
// directly on PREADY/PSLVERR/PRDATA. The timeout sequence is only present
// when APB_MASTER_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_apb_master_nslv;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            PCLK;
    logic            PRESET;
    logic [AW-1:0]   PADDR;
    logic            PWRITE;
    logic            PENABLE;
    logic [DW-1:0]   PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic [NS-1:0]   PSEL;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]   PREADY;
    logic [NS-1:0]   PSLVERR;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_strb;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;

    int checks = 0;
    int errors = 0;

    apb_master_nslv dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance to 1 ns after the next rising edge; all driving and sampling
    // happens there, away from the edge itself.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setSlaveData(input int s, input logic [DW-1:0] d);
        PRDATA[s*DW +: DW] = d;
    endtask

    initial begin
        PRESET  = 1'b1;
        PREADY  = '1;
        PSLVERR = '0;
        PRDATA  = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        // Reset values
        #12;
        checkOutput("rst_psel",      PSEL,      0);
        checkOutput("rst_penable",   PENABLE,   0);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_paddr",     PADDR,     0);
        checkOutput("rst_pstrb",     PSTRB,     0);
        tick();
        PRESET = 1'b0;
        tick();

        // Zero-wait write to slave 2
        $display("[TB] write 0x10002004");
        applyStimulus(1'b1, 1'b1, 32'h1000_2004, 32'hA5A5_0001, 4'hF);
        tick();                                           // T+1 SETUP
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("w_setup_psel",    PSEL,      5'b00100);
        checkOutput("w_setup_penable", PENABLE,   0);
        checkOutput("w_setup_ready",   req_ready, 0);
        checkOutput("w_paddr",         PADDR,     32'h1000_2004);
        checkOutput("w_pwdata",        PWDATA,    32'hA5A5_0001);
        checkOutput("w_pstrb",         PSTRB,     4'hF);
        checkOutput("w_pwrite",        PWRITE,    1);
        tick();                                           // T+2 ACCESS
        checkOutput("w_access_psel",    PSEL,      5'b00100);
        checkOutput("w_access_penable", PENABLE,   1);
        checkOutput("w_access_rspv",    rsp_valid, 0);
        tick();                                           // T+3 response
        checkOutput("w_rsp_valid", rsp_valid, 1);
        checkOutput("w_rsp_err",   rsp_err,   0);
        checkOutput("w_rsp_rdata", rsp_rdata, 0);
        checkOutput("w_idle_psel", PSEL,      0);
        checkOutput("w_idle_ready", req_ready, 1);
        checkOutput("w_paddr_hold", PADDR,    32'h1000_2004);

        // Back-to-back read from slave 4 with three wait cycles
        $display("[TB] read 0x10004010 with waits");
        setSlaveData(4, 32'hDEAD_BEEF);
        PREADY = 5'b01111;
        applyStimulus(1'b1, 1'b0, 32'h1000_4010, 32'h0, 4'hF);
        tick();                                           // T+1 SETUP
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("r_setup_psel", PSEL,      5'b10000);
        checkOutput("r_pstrb_read", PSTRB,     4'h0);
        checkOutput("r_pwrite",     PWRITE,    0);
        checkOutput("r_rspv_once",  rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin                 // T+2..T+4 waits
            tick();
            checkOutput("r_wait_psel",    PSEL,      5'b10000);
            checkOutput("r_wait_penable", PENABLE,   1);
            checkOutput("r_wait_rspv",    rsp_valid, 0);
        end
        tick();                                           // T+5 last ACCESS
        checkOutput("r_last_psel", PSEL, 5'b10000);
        PREADY = '1;
        tick();                                           // T+6 response
        checkOutput("r_rsp_valid", rsp_valid, 1);
        checkOutput("r_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("r_rsp_err",   rsp_err,   0);
        checkOutput("r_idle_psel", PSEL,      0);

        // Out-of-range read: no bus cycle, error next cycle
        $display("[TB] read 0x10005000 (miss)");
        applyStimulus(1'b1, 1'b0, 32'h1000_5000, 32'h0, 4'h0);
        checkOutput("m_ready_T", req_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("m_psel",      PSEL,      0);
        checkOutput("m_rsp_valid", rsp_valid, 1);
        checkOutput("m_rsp_err",   rsp_err,   1);
        checkOutput("m_rsp_rdata", rsp_rdata, 0);
        checkOutput("m_ready",     req_ready, 1);
        checkOutput("m_paddr",     PADDR,     32'h1000_5000);
        tick();
        checkOutput("m_rspv_drop", rsp_valid, 0);
        checkOutput("m_psel2",     PSEL,      0);

        // Just below the base is also a miss
        applyStimulus(1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("lo_psel",    PSEL,    0);
        checkOutput("lo_rsp_err", rsp_err, 1);
        tick();

        // Slave 1 error with ready
        $display("[TB] read slave 1 with PSLVERR");
        setSlaveData(1, 32'h1234_5678);
        PSLVERR = 5'b00010;
        applyStimulus(1'b1, 1'b0, 32'h1000_1000, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("e_access_psel", PSEL, 5'b00010);
        tick();
        checkOutput("e_rsp_valid", rsp_valid, 1);
        checkOutput("e_rsp_err",   rsp_err,   1);
        checkOutput("e_rsp_rdata", rsp_rdata, 0);
        PSLVERR = '0;

        // Clean read at the top of slave 2's window
        setSlaveData(2, 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b0, 32'h1000_2FFC, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("t_setup_psel", PSEL, 5'b00100);
        tick();
        tick();
        checkOutput("t_rsp_valid", rsp_valid, 1);
        checkOutput("t_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        checkOutput("t_rsp_err",   rsp_err,   0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout after 16 ACCESS cycles with PREADY low
        $display("[TB] timeout on slave 3");
        PREADY = '0;
        setSlaveData(3, 32'h0BAD_F00D);
        applyStimulus(1'b1, 1'b0, 32'h1000_3000, 32'h0, 4'h0);
        tick();                                           // T+1
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 16; i++) begin                // T+2..T+17
            tick();
            checkOutput("to_penable", PENABLE,   1);
            checkOutput("to_rspv",    rsp_valid, 0);
        end
        tick();                                           // T+18
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_err",   rsp_err,   1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_psel",      PSEL,      0);
        tick();

        // Ready in the 16th ACCESS cycle wins over the timeout
        applyStimulus(1'b1, 1'b0, 32'h1000_3000, 32'h0, 4'h0);
        tick();                                           // T+1
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 15; i++) begin                // T+2..T+16
            tick();
        end
        tick();                                           // T+17
        checkOutput("tr_penable", PENABLE, 1);
        PREADY = '1;
        tick();                                           // T+18
        checkOutput("tr_rsp_valid", rsp_valid, 1);
        checkOutput("tr_rsp_err",   rsp_err,   0);
        checkOutput("tr_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();
`endif

        // Reset in the middle of ACCESS
        $display("[TB] reset during ACCESS");
        PREADY = 5'b11110;
        applyStimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("x_access_psel",    PSEL,    5'b00001);
        checkOutput("x_access_penable", PENABLE, 1);
        #1;
        PRESET = 1'b1;
        #1;
        checkOutput("x_psel_async",    PSEL,    0);
        checkOutput("x_penable_async", PENABLE, 0);
        tick();
        PRESET = 1'b0;
        PREADY = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("x_no_rspv", rsp_valid, 0);
            checkOutput("x_ready",   req_ready, 1);
            checkOutput("x_psel",    PSEL,      0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
